// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl: multiplexed scan controller for a 4-digit seven-segment display.
//   clk, rst   : system clock (rising edge), asynchronous active-high reset
//   load       : one-cycle strobe capturing value / dp_in / blank_lz into a pending buffer
//   value      : four BCD digits, digit0 = [3:0]
//   dp_in      : decimal point per digit
//   blank_lz   : leading-zero blanking enable
//   an         : one-hot digit enable (active-high), registered
//   seg        : segments a..g on bit0..bit6 (active-high), registered
//   dp         : decimal point of the shown digit, registered
//   frame_tick : high in the frame-boundary cycle (idx = 3, last cycle of slot)
//   pending    : captured data waiting for the next frame boundary
module ssd_scan_ctrl #(
  parameter int SLOT_CYC  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick,
  output logic        pending
);

  localparam int CW = $clog2(SLOT_CYC);
  localparam logic [CW-1:0] CNT_MAX    = CW'(SLOT_CYC - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

  typedef enum logic {BLANK = 1'b0, SHOW = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic          slot_end, boundary;

  logic [15:0] disp_val, pend_val;
  logic [3:0]  disp_dp, pend_dp;
  logic        disp_lz, pend_lz;

  logic [3:0]  nib;
  logic [6:0]  seg_dec;
  logic [1:0]  hi;
  logic        blank_digit;
  logic [3:0]  an_nxt;
  logic [6:0]  seg_nxt;
  logic        dp_nxt;

  assign slot_end   = (cnt == CNT_MAX);
  assign boundary   = slot_end && (idx == 2'd3);
  assign frame_tick = boundary;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      idx   <= '0;
      state <= BLANK;
    end else begin
      cnt   <= slot_end ? '0 : cnt + 1'b1;
      idx   <= slot_end ? idx + 2'd1 : idx;
      state <= state_nxt;
    end
  end

  // Display register only moves at the boundary; a load landing on the boundary
  // bypasses the pending buffer so the freshest data is shown next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_val <= '0;
      disp_dp  <= '0;
      disp_lz  <= 1'b0;
      pend_val <= '0;
      pend_dp  <= '0;
      pend_lz  <= 1'b0;
      pending  <= 1'b0;
    end else begin
      if (load) begin
        pend_val <= value;
        pend_dp  <= dp_in;
        pend_lz  <= blank_lz;
        pending  <= 1'b1;
      end
      if (boundary) begin
        pending <= 1'b0;
        if (load) begin
          disp_val <= value;
          disp_dp  <= dp_in;
          disp_lz  <= blank_lz;
        end else if (pending) begin
          disp_val <= pend_val;
          disp_dp  <= pend_dp;
          disp_lz  <= pend_lz;
        end
      end
    end
  end

  always_comb begin
    nib = disp_val[{idx, 2'b00} +: 4];
    case (nib)
      4'd0:    seg_dec = 7'h3F;
      4'd1:    seg_dec = 7'h06;
      4'd2:    seg_dec = 7'h5B;
      4'd3:    seg_dec = 7'h4F;
      4'd4:    seg_dec = 7'h66;
      4'd5:    seg_dec = 7'h6D;
      4'd6:    seg_dec = 7'h7D;
      4'd7:    seg_dec = 7'h07;
      4'd8:    seg_dec = 7'h7F;
      4'd9:    seg_dec = 7'h67;
      default: seg_dec = 7'h00;
    endcase
  end

  // Highest nonzero nibble position; stays 0 for an all-zero value so digit0 is never blanked.
  always_comb begin
    hi = '0;
    for (int unsigned i = 1; i < 4; i++) begin
      if (disp_val[i*4 +: 4] != 4'h0) hi = 2'(i);
    end
  end

  assign blank_digit = disp_lz && (idx > hi);

  always_comb begin
    state_nxt = state;
    an_nxt    = '0;
    seg_nxt   = '0;
    dp_nxt    = 1'b0;
    if (slot_end)               state_nxt = BLANK;
    else if (cnt == BLANK_LAST) state_nxt = SHOW;
    if (state == SHOW && !blank_digit) begin
      an_nxt  = 4'b0001 << idx;
      seg_nxt = seg_dec;
      dp_nxt  = disp_dp[idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an  <= '0;
      seg <= '0;
      dp  <= 1'b0;
    end else begin
      an  <= an_nxt;
      seg <= seg_nxt;
      dp  <= dp_nxt;
    end
  end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// tb_ssd_scan_ctrl: randomized + directed bench for ssd_scan_ctrl (SLOT_CYC = 8, BLANK_CYC = 2)
// against a time-indexed behavioural model of the scan.
module tb_ssd_scan_ctrl;

  localparam int SLOT  = 8;
  localparam int BLANK = 2;
  localparam int FRAME = 4 * SLOT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic        blank_lz = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;
  logic        pending;

  ssd_scan_ctrl #(.SLOT_CYC(SLOT), .BLANK_CYC(BLANK)) dut (
    .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in),
    .blank_lz(blank_lz), .an(an), .seg(seg), .dp(dp),
    .frame_tick(frame_tick), .pending(pending)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [6:0] dec_tab [0:15] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h67, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};

  // model: t = cycles since reset release
  int          t = 0;
  logic [15:0] dv = '0, pv = '0;
  logic [3:0]  dd = '0, pd = '0;
  logic        dl = 1'b0, pl = 1'b0, pnd = 1'b0;

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    if (obs != exp) begin
      miscompares++;
      $display("FAIL %s at t=%0t: got %0h, want %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic step();
    int c, i, hi;
    logic [3:0] ea;
    logic [6:0] es;
    logic       ed;
    logic [15:0] tmp;
    logic bnd;
    @(posedge clk);
    ea = '0; es = '0; ed = 1'b0;
    if (rst) begin
      t = 0; dv = '0; pv = '0; dd = '0; pd = '0; dl = 0; pl = 0; pnd = 0;
    end else begin
      c = t % SLOT;
      i = (t / SLOT) % 4;
      hi = 0;
      tmp = dv;
      for (int k = 0; k < 4; k++) if (((tmp >> (4*k)) & 16'hF) != 0) hi = k;
      if (c >= BLANK && (!dl || i <= hi)) begin
        ea = 4'(1 << i);
        es = dec_tab[(tmp >> (4*i)) & 16'hF];
        ed = dd[i];
      end
      bnd = (t % FRAME) == FRAME - 1;
      if (load) begin pv = value; pd = dp_in; pl = blank_lz; pnd = 1'b1; end
      if (bnd) begin
        if (pnd) begin dv = pv; dd = pd; dl = pl; end
        pnd = 1'b0;
      end
      t++;
    end
    #1;
    check("an", int'(an), int'(ea));
    check("seg", int'(seg), int'(es));
    check("dp", int'(dp), int'(ed));
    check("frame_tick", int'(frame_tick), int'((t % FRAME) == FRAME - 1));
    check("pending", int'(pending), int'(pnd));
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic lz);
    value = v; dp_in = d; blank_lz = lz; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  // advance until the next edge is the frame-boundary cycle
  task automatic to_boundary();
    while ((t % FRAME) != FRAME - 1) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state, with a load strobe that must be ignored
    load = 1'b1; value = 16'h9999;
    step();
    load = 1'b0;
    step();
    @(negedge clk); rst = 1'b0;

    // basic digits
    do_load(16'h1234, 4'b0000, 1'b0);
    run(2 * FRAME);
    // leading-zero blanking
    do_load(16'h0070, 4'b0000, 1'b1);
    run(2 * FRAME);
    // latest-wins while pending
    do_load(16'h1111, 4'b0000, 1'b0);
    to_boundary(); step();
    run(5);
    do_load(16'h2222, 4'b0000, 1'b0);
    run(7);
    do_load(16'h3333, 4'b0000, 1'b0);
    run(2 * FRAME);
    // load on the boundary cycle
    to_boundary();
    do_load(16'h0009, 4'b0001, 1'b0);
    run(FRAME + 2);
    // A-F nibble decodes blank with an asserted
    do_load(16'h00A5, 4'b0010, 1'b1);
    run(2 * FRAME);
    // async reset during SHOW with data pending
    do_load(16'h8888, 4'b1111, 1'b0);
    while ((t % SLOT) != 4) step();
    #2 rst = 1'b1;
    #1;
    check("async_an", int'(an), 0);
    check("async_seg", int'(seg), 0);
    check("async_dp", int'(dp), 0);
    check("async_pending", int'(pending), 0);
    step();
    @(negedge clk); rst = 1'b0;
    run(FRAME + 4);

    // randomized loads
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 15) == 0) do_load(16'($urandom), 4'($urandom), 1'($urandom));
      else step();
    end
    // random loads forced onto boundaries
    for (int n = 0; n < 6; n++) begin
      to_boundary();
      do_load(16'($urandom), 4'($urandom), 1'($urandom));
    end
    run(FRAME);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ssd_scan_ctrl.md
SSD_SCAN_CTRL -- requirements
Module: ssd_scan_ctrl

Interface
REQ-001 Parameter SLOT_CYC, default 50000: clock cycles per digit slot; SHALL be >= 4.
REQ-002 Parameter BLANK_CYC, default 500: anti-ghost blank cycles at the start of each slot; SHALL satisfy 1 <= BLANK_CYC < SLOT_CYC.
REQ-003 Port list SHALL be exactly as follows (clock and reset first):
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- load  in  1  one-cycle strobe that captures value, dp_in and blank_lz.
- value  in  16  four BCD digits; digit0 = [3:0] (least significant), digit3 = [15:12].
- dp_in  in  4  decimal point per digit; bit i belongs to digit i.
- blank_lz  in  1  leading-zero blanking enable.
- an  out  4  one-hot digit enable, active-high; bit i = digit i.
- seg  out  7  segments, active-high; bit0 = a ... bit6 = g.
- dp  out  1  decimal point of the digit currently shown.
- frame_tick  out  1  one-cycle pulse at each frame boundary.
- pending  out  1  high while captured data is waiting for a frame boundary.

Function
REQ-004 Slot counter cnt SHALL count 0..SLOT_CYC-1 and wrap; digit index idx SHALL increment when cnt = SLOT_CYC-1 and wrap from 3 to 0 (scan order 0,1,2,3).
REQ-005 FSM SHALL have two states: BLANK while cnt < BLANK_CYC, SHOW otherwise; BLANK -> SHOW at cnt = BLANK_CYC, SHOW -> BLANK at slot wrap.
REQ-006 In BLANK, outputs SHALL be an = 0, seg = 0 and dp = 0.
REQ-007 In SHOW, an SHALL be one-hot(idx), seg SHALL be decode(display nibble idx) and dp SHALL be display dp bit idx.
REQ-008 an, seg and dp SHALL be registered, so that they reflect the cnt/idx/state of the previous cycle (1-cycle latency).
REQ-009 Decode SHALL be active-high with no decimal point: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=67; any nibble A-F SHALL produce seg = 00, with an still asserted.
REQ-010 On load, value, dp_in and blank_lz SHALL be written to a pending register and pending SHALL be set to 1; a new load while pending = 1 SHALL overwrite the pending register (latest wins).
REQ-011 Frame boundary is the cycle with idx = 3 and cnt = SLOT_CYC-1; in that cycle frame_tick SHALL be 1, pending contents SHALL transfer to the display register, and pending SHALL clear.
REQ-012 If load coincides with the boundary, the newly loaded data SHALL transfer directly to the display register and pending SHALL end at 0.
REQ-013 The display register SHALL change only at frame boundaries, so no frame ever mixes old and new digits.
REQ-014 With the display-register blank_lz = 1, every digit above the highest nonzero nibble SHALL be shown as in BLANK (an = 0); digit0 SHALL never be blanked; nibbles A-F SHALL count as nonzero.
REQ-015 Inputs SHALL be sampled only at rising edges; load SHALL be ignored while rst = 1.

Reset
REQ-016 When rst is asserted, the block SHALL asynchronously clear cnt, idx, the display register, the pending register, pending, an, seg, dp and frame_tick to 0, and the state SHALL be BLANK.
REQ-017 Reset asserted mid-frame SHALL discard pending data.
REQ-018 After reset release, the first slot SHALL be digit0 starting in BLANK.

Verification (SLOT_CYC = 8, BLANK_CYC = 2)
REQ-019 Load 1234h (dp_in = 0, blank_lz = 0) after reset -> after the boundary, each slot shows an = 0 for 2 cycles and then an one-hot for 6 cycles; seg sequence 66, 4F, 5B, 06 for digits 0 to 3.
REQ-020 Load 0070h with blank_lz = 1 -> an[3] and an[2] never assert; digit1 seg = 07 and digit0 seg = 3F.
REQ-021 Display showing 1111h; mid-frame load 2222h, then load 3333h before the boundary -> 06 is shown on all digits until the boundary, then 4F is shown on all digits; 5B is never shown; pending stays 1 until frame_tick.
REQ-022 Load 0009h with dp_in = 0001b asserted exactly on the boundary cycle -> the next frame shows digit0 seg = 67 with dp = 1; pending = 0 throughout.
REQ-023 Load 00A5h -> digit1 slot shows an = 0010b with seg = 00; digit0 slot shows seg = 6D.
REQ-024 rst pulsed during a SHOW slot with pending = 1 -> an, seg and dp go to 0 without waiting for a clock edge; after release, pending = 0, display = 0000h and digit0 shows 3F.
